// File: rtl/cdb_select.sv
// cdb_select: complete-stage arbiter. Grants up to N prepared functional-unit
// results per cycle onto the common data bus in round-robin order, returns
// same-cycle avail grants to the units and registers the CDB broadcast.
module cdb_select #(
  parameter int N        = 2,
  parameter int NUM_ALU  = 3,
  parameter int NUM_MULT = 2,
  parameter int NUM_LOAD = 1,
  parameter int PRN_W    = 6,
  parameter int ROBN_W   = 5,
  localparam int S       = NUM_ALU + NUM_MULT + NUM_LOAD,
  localparam int CNT_W   = $clog2(N + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  squash,
  input  logic [S-1:0]          prepared,
  input  logic [S*PRN_W-1:0]    src_prn,
  input  logic [S*ROBN_W-1:0]   src_robn,
  input  logic [S*32-1:0]       src_data,
  output logic [NUM_ALU-1:0]    alu_avail,
  output logic [NUM_MULT-1:0]   mult_avail,
  output logic [NUM_LOAD-1:0]   load_avail,
  output logic [N-1:0]          cdb_valid,
  output logic [N*PRN_W-1:0]    cdb_prn,
  output logic [N*ROBN_W-1:0]   cdb_robn,
  output logic [N*32-1:0]       cdb_data,
  output logic [CNT_W-1:0]      cdb_count,
  output logic [31:0]           busy_cycles
);

  localparam int SRC_W = (S > 1) ? $clog2(S) : 1;

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] next_ptr;
  logic [S-1:0]     grant;
  logic [SRC_W-1:0] lane_src [N];
  logic [N-1:0]     lane_vld;
  logic [CNT_W-1:0] grant_cnt;

  // Round-robin scan from rr_ptr; the k-th grant found feeds CDB lane k.
  always_comb begin
    int cnt;
    int pos;
    grant     = '0;
    lane_vld  = '0;
    next_ptr  = rr_ptr;
    cnt       = 0;
    pos       = 0;
    for (int k = 0; k < N; k++) begin
      lane_src[k] = '0;
    end
    if (!squash) begin
      for (int i = 0; i < S; i++) begin
        pos = int'(rr_ptr) + i;
        if (pos >= S) begin
          pos = pos - S;
        end else begin
          pos = pos;
        end
        if (prepared[SRC_W'(pos)] && (cnt < N)) begin
          grant[SRC_W'(pos)] = 1'b1;
          for (int k = 0; k < N; k++) begin
            if (k == cnt) begin
              lane_src[k] = SRC_W'(pos);
              lane_vld[k] = 1'b1;
            end else begin
              lane_src[k] = lane_src[k];
            end
          end
          cnt      = cnt + 1;
          // Pointer moves just past the last source granted, wrapping to 0.
          next_ptr = (pos == S - 1) ? '0 : SRC_W'(pos + 1);
        end else begin
          cnt = cnt;
        end
      end
    end else begin
      cnt = 0;
    end
    grant_cnt = CNT_W'(cnt);
  end

  assign alu_avail  = grant[NUM_ALU-1:0];
  assign mult_avail = grant[NUM_ALU+NUM_MULT-1:NUM_ALU];
  assign load_avail = grant[S-1:NUM_ALU+NUM_MULT];

  // Round-robin pointer: advances on any grant, returns to 0 on a flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (squash) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= next_ptr;
    end
  end

  // CDB broadcast registers: granted results appear one cycle after grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid <= '0;
      cdb_prn   <= '0;
      cdb_robn  <= '0;
      cdb_data  <= '0;
      cdb_count <= '0;
    end else if (squash) begin
      cdb_valid <= '0;
      cdb_prn   <= '0;
      cdb_robn  <= '0;
      cdb_data  <= '0;
      cdb_count <= '0;
    end else begin
      cdb_valid <= lane_vld;
      cdb_count <= grant_cnt;
      for (int k = 0; k < N; k++) begin
        if (lane_vld[k]) begin
          cdb_prn[k*PRN_W +: PRN_W]   <= src_prn[int'(lane_src[k])*PRN_W +: PRN_W];
          cdb_robn[k*ROBN_W +: ROBN_W] <= src_robn[int'(lane_src[k])*ROBN_W +: ROBN_W];
          cdb_data[k*32 +: 32]         <= src_data[int'(lane_src[k])*32 +: 32];
        end else begin
          cdb_prn[k*PRN_W +: PRN_W]   <= '0;
          cdb_robn[k*ROBN_W +: ROBN_W] <= '0;
          cdb_data[k*32 +: 32]         <= '0;
        end
      end
    end
  end

  // Utilisation counter: counts cycles with a live broadcast, saturating;
  // a flush does not clear it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_cycles <= 32'd0;
    end else if ((|cdb_valid) && (busy_cycles != 32'hFFFF_FFFF)) begin
      busy_cycles <= busy_cycles + 32'd1;
    end else begin
      busy_cycles <= busy_cycles;
    end
  end

endmodule

// File: tb/tb_cdb_select.sv
// Directed table-driven bench for cdb_select (N=2, S=6).
module tb_cdb_select;

  localparam int N = 2;
  localparam int S = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          squash;
  logic [5:0]    prepared;
  logic [35:0]   src_prn;
  logic [29:0]   src_robn;
  logic [191:0]  src_data;
  logic [2:0]    alu_avail;
  logic [1:0]    mult_avail;
  logic [0:0]    load_avail;
  logic [1:0]    cdb_valid;
  logic [11:0]   cdb_prn;
  logic [9:0]    cdb_robn;
  logic [63:0]   cdb_data;
  logic [1:0]    cdb_count;
  logic [31:0]   busy_cycles;

  cdb_select dut (
    .clock(clock), .reset(reset), .squash(squash), .prepared(prepared),
    .src_prn(src_prn), .src_robn(src_robn), .src_data(src_data),
    .alu_avail(alu_avail), .mult_avail(mult_avail), .load_avail(load_avail),
    .cdb_valid(cdb_valid), .cdb_prn(cdb_prn), .cdb_robn(cdb_robn),
    .cdb_data(cdb_data), .cdb_count(cdb_count), .busy_cycles(busy_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       sq;
    logic [5:0] prep;
    logic [5:0] avail;  // {load, mult, alu}
    int         l0;     // source expected on lane 0, -1 = none
    int         l1;
  } vec_t;

  vec_t        vecs [14];
  logic [5:0]  t_prn  [S];
  logic [4:0]  t_robn [S];
  logic [31:0] t_data [S];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_lane(input string name, input int k, input int src);
    logic [42:0] act;
    logic [42:0] exp;
    act = {cdb_prn[k*6 +: 6], cdb_robn[k*5 +: 5], cdb_data[k*32 +: 32]};
    if (src < 0) exp = '0;
    else exp = {t_prn[src], t_robn[src], t_data[src]};
    chk(name, 64'(act), 64'(exp));
  endtask

  initial begin
    int n_valid;
    int exp_busy;
    logic [1:0] ev;

    // Source 0 carries robn=3 / data=CAFE; others are distinct.
    for (int i = 0; i < S; i++) begin
      t_prn[i]  = 6'(20 + i);
      t_robn[i] = 5'(8 + i);
      t_data[i] = 32'h0000_1000 + 32'(i);
    end
    t_robn[0] = 5'd3;
    t_data[0] = 32'h0000_CAFE;
    for (int i = 0; i < S; i++) begin
      src_prn[i*6 +: 6]   = t_prn[i];
      src_robn[i*5 +: 5]  = t_robn[i];
      src_data[i*32 +: 32] = t_data[i];
    end

    vecs[0]  = '{1'b0, 6'b000001, 6'b000001, 0, -1};  // rr 0 -> 1
    vecs[1]  = '{1'b1, 6'b011000, 6'b000000, -1, -1}; // squash, rr -> 0
    vecs[2]  = '{1'b0, 6'b111111, 6'b000011, 0, 1};   // rr -> 2
    vecs[3]  = '{1'b0, 6'b111111, 6'b001100, 2, 3};   // rr -> 4
    vecs[4]  = '{1'b0, 6'b111111, 6'b110000, 4, 5};   // rr -> 0
    vecs[5]  = '{1'b0, 6'b000000, 6'b000000, -1, -1}; // rr stays 0
    vecs[6]  = '{1'b0, 6'b010000, 6'b010000, 4, -1};  // rr -> 5
    vecs[7]  = '{1'b0, 6'b100001, 6'b100001, 5, 0};   // wrap, rr -> 1
    vecs[8]  = '{1'b0, 6'b000001, 6'b000001, 0, -1};  // rr -> 1
    vecs[9]  = '{1'b0, 6'b000011, 6'b000011, 1, 0};   // rr -> 1
    vecs[10] = '{1'b1, 6'b011000, 6'b000000, -1, -1}; // squash, rr -> 0
    vecs[11] = '{1'b0, 6'b011000, 6'b011000, 3, 4};   // rr -> 5
    vecs[12] = '{1'b0, 6'b000110, 6'b000110, 1, 2};   // rr -> 3
    vecs[13] = '{1'b0, 6'b001110, 6'b001010, 3, 1};   // rr -> 2

    reset    = 1'b1;
    squash   = 1'b0;
    prepared = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_valid", 64'(cdb_valid), 64'd0);
    chk("reset_count", 64'(cdb_count), 64'd0);
    chk("reset_busy", 64'(busy_cycles), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Table: drive at negedge, check avail immediately, lanes after the edge.
    exp_busy = 0;
    for (int r = 0; r < 14; r++) begin
      @(negedge clock);
      squash   = vecs[r].sq;
      prepared = vecs[r].prep;
      #1;
      chk($sformatf("avail_r%0d", r), 64'({load_avail, mult_avail, alu_avail}), 64'(vecs[r].avail));
      @(posedge clock);
      #1;
      ev = {vecs[r].l1 >= 0, vecs[r].l0 >= 0};
      n_valid = int'(ev[0]) + int'(ev[1]);
      chk($sformatf("valid_r%0d", r), 64'(cdb_valid), 64'(ev));
      chk($sformatf("count_r%0d", r), 64'(cdb_count), 64'(n_valid));
      chk_lane($sformatf("lane0_r%0d", r), 0, vecs[r].l0);
      chk_lane($sformatf("lane1_r%0d", r), 1, vecs[r].l1);
      if (r < 13 && n_valid != 0) exp_busy++;
    end
    chk("busy_after_table", 64'(busy_cycles), 64'(exp_busy));

    // Asynchronous reset mid-cycle while both lanes are valid.
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 64'(cdb_valid), 64'd0);
    chk("async_count", 64'(cdb_count), 64'd0);
    chk("async_fields", 64'(|{cdb_prn, cdb_robn, cdb_data}), 64'd0);
    chk("async_busy", 64'(busy_cycles), 64'd0);
    // rr_ptr back at 0: 001110 now grants sources 1,2 rather than 2,3.
    chk("async_rr", 64'({load_avail, mult_avail, alu_avail}), 64'(6'b000110));
    @(negedge clock);
    reset    = 1'b0;
    squash   = 1'b0;
    prepared = 6'b000011;

    // Saturation of busy_cycles from a preloaded near-max value.
    @(negedge clock);
    force dut.busy_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.busy_cycles;
    @(posedge clock);
    #1;
    chk("busy_to_max", 64'(busy_cycles), 64'hFFFF_FFFF);
    @(posedge clock);
    #1;
    chk("busy_hold_max", 64'(busy_cycles), 64'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
